// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared types and constants for the CPU memory responder: FSM state encoding,
// latency counter width, bus widths, write payload struct and the LFSR
// constants used by the optional random-delay feature (MEM_RAND_DELAY_EN).
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned LFSR_W = 8;

  // Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } fsm_state_e;

  // Latched write request payload
  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // Wait-count load value; saturates so the extra random cycles never wrap
  function automatic logic [CNT_W-1:0] lat_load(input logic [CNT_W-1:0] lat,
                                                input logic [1:0]       extra);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, lat} + SUM_W'(extra);
    lat_load = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder_if
// CPU <-> memory responder bus.
//   instruction channel : pc, inst_req_valid, inst_req_ack,
//                         instruction, inst_valid, inst_ack
//   data channel        : address, mem_write, write_data, write_strb, mem_read,
//                         mem_req_ack, read_data, read_data_valid, read_data_ack
//   status              : prot_err (sticky)
// master = CPU side, slave = responder side.
// -----------------------------------------------------------------------------
interface cpu_mem_responder_if;
  import cpu_mem_pkg::*;

  logic [XLEN-1:0]   pc;
  logic              inst_req_valid;
  logic              inst_req_ack;
  logic [XLEN-1:0]   instruction;
  logic              inst_valid;
  logic              inst_ack;

  logic [XLEN-1:0]   address;
  logic              mem_write;
  logic [XLEN-1:0]   write_data;
  logic [STRB_W-1:0] write_strb;
  logic              mem_read;
  logic              mem_req_ack;
  logic [XLEN-1:0]   read_data;
  logic              read_data_valid;
  logic              read_data_ack;

  logic              prot_err;

  modport master (
    output pc, inst_req_valid, inst_ack,
    output address, mem_write, write_data, write_strb, mem_read, read_data_ack,
    input  inst_req_ack, instruction, inst_valid,
    input  mem_req_ack, read_data, read_data_valid, prot_err
  );

  modport slave (
    input  pc, inst_req_valid, inst_ack,
    input  address, mem_write, write_data, write_strb, mem_read, read_data_ack,
    output inst_req_ack, instruction, inst_valid,
    output mem_req_ack, read_data, read_data_valid, prot_err
  );

endinterface

// File: rtl/mem_resp_dpram.sv
// -----------------------------------------------------------------------------
// mem_resp_dpram
// 2^ADDR_W x 32 storage with two synchronous read ports (a, b) and one
// byte-strobed write port. Read data registers update only when their enable
// is high and otherwise hold; they clear on reset. A read and a write to the
// same word on the same edge return the old word. Array contents are not reset.
// Ports: clk, rst (async, active-low), a_en/a_addr/a_data, b_en/b_addr/b_data,
//        wr_en/wr_addr/wr_data/wr_strb.
// -----------------------------------------------------------------------------
module mem_resp_dpram
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [XLEN-1:0]   a_data,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [XLEN-1:0]   b_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [STRB_W-1:0] wr_strb
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [XLEN-1:0] mem [DEPTH];

  // Byte-lane write port
  always_ff @(posedge clk) begin : write_port
    if (wr_en) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read ports; output registers hold between enables
  always_ff @(posedge clk or negedge rst) begin : read_ports
    if (!rst) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_en) a_data <= mem[a_addr];
      if (b_en) b_data <= mem[b_addr];
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
// Memory model that answers a CPU's instruction fetches and data loads/stores
// through two independent IDLE/ACK/WAIT/RESP state machines sharing one
// storage block (mem_resp_dpram).
// Parameters: ADDR_W (word-address width), INST_LAT, DATA_LAT (wait cycles).
// Ports: clk, rst (async, active-low), bus (cpu_mem_responder_if.slave).
// Optional: define MEM_RAND_DELAY_EN to add 0..3 pseudo-random wait cycles
//           (8-bit LFSR) to every WAIT count load.
// -----------------------------------------------------------------------------
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned INST_LAT = 1,
  parameter int unsigned DATA_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  cpu_mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] INST_LAT_C = CNT_W'(INST_LAT);
  localparam logic [CNT_W-1:0] DATA_LAT_C = CNT_W'(DATA_LAT);

  // ---------------------------------------------------------------------------
  // Extra wait cycles (zero unless the random-delay feature is built)
  // ---------------------------------------------------------------------------
  logic [1:0] extra_dly_c;

`ifdef MEM_RAND_DELAY_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin : lfsr_reg
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= lfsr_next(lfsr);
  end

  assign extra_dly_c = lfsr[1:0];
`else
  assign extra_dly_c = 2'b00;
`endif

  logic [CNT_W-1:0] inst_load_c;
  logic [CNT_W-1:0] data_load_c;

  assign inst_load_c = lat_load(INST_LAT_C, extra_dly_c);
  assign data_load_c = lat_load(DATA_LAT_C, extra_dly_c);

  // Only the word-index bits of the byte addresses are used
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.pc[1:0], bus.pc[XLEN-1:ADDR_W+2],
                              bus.address[1:0], bus.address[XLEN-1:ADDR_W+2]};

  // ---------------------------------------------------------------------------
  // Instruction FSM
  // ---------------------------------------------------------------------------
  fsm_state_e        i_state, i_state_d;
  logic [CNT_W-1:0]  i_cnt, i_cnt_d;
  logic [ADDR_W-1:0] i_addr, i_addr_d;
  logic              i_req_ack;
  logic              i_valid;
  logic              i_rd_en_c;

  always_ff @(posedge clk or negedge rst) begin : inst_regs
    if (!rst) begin
      i_state   <= ST_IDLE;
      i_cnt     <= '0;
      i_addr    <= '0;
      i_req_ack <= 1'b0;
      i_valid   <= 1'b0;
    end else begin
      i_state   <= i_state_d;
      i_cnt     <= i_cnt_d;
      i_addr    <= i_addr_d;
      i_req_ack <= (i_state_d == ST_ACK);
      i_valid   <= (i_state_d == ST_RESP);
    end
  end

  always_comb begin : inst_next
    i_state_d = i_state;
    i_cnt_d   = i_cnt;
    i_addr_d  = i_addr;
    unique case (i_state)
      ST_IDLE: begin
        if (bus.inst_req_valid) begin
          i_addr_d  = bus.pc[ADDR_W+1:2];
          i_state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        i_cnt_d   = inst_load_c;
        i_state_d = (inst_load_c != '0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        i_cnt_d = i_cnt - CNT_W'(1);
        if (i_cnt <= CNT_W'(1)) i_state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.inst_ack) i_state_d = ST_IDLE;
      end
      default: i_state_d = ST_IDLE;
    endcase
  end

  // Capture the word on the edge that enters RESP
  assign i_rd_en_c = (i_state != ST_RESP) && (i_state_d == ST_RESP);

  // ---------------------------------------------------------------------------
  // Data FSM
  // ---------------------------------------------------------------------------
  fsm_state_e        d_state, d_state_d;
  logic [CNT_W-1:0]  d_cnt, d_cnt_d;
  logic [ADDR_W-1:0] d_addr, d_addr_d;
  wr_req_t           d_wr, d_wr_d;
  logic              d_is_wr, d_is_wr_d;
  logic              prot_err, prot_err_d;
  logic              d_req_ack;
  logic              d_valid;
  logic              d_rd_en_c;
  logic              wr_en_c;

  always_ff @(posedge clk or negedge rst) begin : data_regs
    if (!rst) begin
      d_state   <= ST_IDLE;
      d_cnt     <= '0;
      d_addr    <= '0;
      d_wr      <= '0;
      d_is_wr   <= 1'b0;
      prot_err  <= 1'b0;
      d_req_ack <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      d_state   <= d_state_d;
      d_cnt     <= d_cnt_d;
      d_addr    <= d_addr_d;
      d_wr      <= d_wr_d;
      d_is_wr   <= d_is_wr_d;
      prot_err  <= prot_err_d;
      d_req_ack <= (d_state_d == ST_ACK);
      d_valid   <= (d_state_d == ST_RESP);
    end
  end

  always_comb begin : data_next
    d_state_d  = d_state;
    d_cnt_d    = d_cnt;
    d_addr_d   = d_addr;
    d_wr_d     = d_wr;
    d_is_wr_d  = d_is_wr;
    prot_err_d = prot_err;
    unique case (d_state)
      ST_IDLE: begin
        // Write wins a simultaneous read; the dropped read is flagged
        if (bus.mem_write) begin
          d_addr_d  = bus.address[ADDR_W+1:2];
          d_wr_d    = '{data: bus.write_data, strb: bus.write_strb};
          d_is_wr_d = 1'b1;
          d_state_d = ST_ACK;
          if (bus.mem_read) prot_err_d = 1'b1;
        end else if (bus.mem_read) begin
          d_addr_d  = bus.address[ADDR_W+1:2];
          d_is_wr_d = 1'b0;
          d_state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (d_is_wr) begin
          d_state_d = ST_IDLE;
        end else begin
          d_cnt_d   = data_load_c;
          d_state_d = (data_load_c != '0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        d_cnt_d = d_cnt - CNT_W'(1);
        if (d_cnt <= CNT_W'(1)) d_state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.read_data_ack) d_state_d = ST_IDLE;
      end
      default: d_state_d = ST_IDLE;
    endcase
  end

  assign d_rd_en_c = (d_state != ST_RESP) && (d_state_d == ST_RESP);

  // Write commits on the edge leaving ACK; reset in ACK drops it
  assign wr_en_c = (d_state == ST_ACK) && d_is_wr;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] inst_word;
  logic [XLEN-1:0] data_word;

  mem_resp_dpram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_en    (i_rd_en_c),
    .a_addr  (i_addr),
    .a_data  (inst_word),
    .b_en    (d_rd_en_c),
    .b_addr  (d_addr),
    .b_data  (data_word),
    .wr_en   (wr_en_c),
    .wr_addr (d_addr),
    .wr_data (d_wr.data),
    .wr_strb (d_wr.strb)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.inst_req_ack    = i_req_ack;
  assign bus.inst_valid      = i_valid;
  assign bus.instruction     = inst_word;
  assign bus.mem_req_ack     = d_req_ack;
  assign bus.read_data_valid = d_valid;
  assign bus.read_data       = data_word;
  assign bus.prot_err        = prot_err;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_responder
// Self-checking bench for cpu_mem_responder (ADDR_W=10, INST_LAT=1,
// DATA_LAT=1). A table of write/fetch/read records with hand-derived expected
// words drives the bus; expected response words go into per-channel queues and
// are popped when the DUT raises its valid. Hand sequences cover the
// write+read conflict, same-edge write/capture, and resets mid-transaction.
// -----------------------------------------------------------------------------
module tb_cpu_mem_responder;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned INST_LAT = 1;
  localparam int unsigned DATA_LAT = 1;

`ifdef MEM_RAND_DELAY_EN
  localparam int EXTRA_MAX = 3;
`else
  localparam int EXTRA_MAX = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_responder_if bus();

  cpu_mem_responder #(
    .ADDR_W   (ADDR_W),
    .INST_LAT (INST_LAT),
    .DATA_LAT (DATA_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] inst_q [$];
  logic [31:0] data_q [$];

  typedef struct {
    bit          is_wr;
    bit          is_inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val >= lo && val <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_inst_req_ack"},    32'(bus.inst_req_ack),    32'h0);
    check({tag, "_inst_valid"},      32'(bus.inst_valid),      32'h0);
    check({tag, "_instruction"},     bus.instruction,          32'h0);
    check({tag, "_mem_req_ack"},     32'(bus.mem_req_ack),     32'h0);
    check({tag, "_read_data_valid"}, 32'(bus.read_data_valid), 32'h0);
    check({tag, "_read_data"},       bus.read_data,            32'h0);
    check({tag, "_prot_err"},        32'(bus.prot_err),        32'h0);
  endtask

  function automatic logic f_ack(input bit is_inst);
    return is_inst ? bus.inst_req_ack : bus.mem_req_ack;
  endfunction

  function automatic logic f_valid(input bit is_inst);
    return is_inst ? bus.inst_valid : bus.read_data_valid;
  endfunction

  function automatic logic [31:0] f_data(input bit is_inst);
    return is_inst ? bus.instruction : bus.read_data;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic also_read);
    @(negedge clk);
    bus.address    = a;
    bus.write_data = d;
    bus.write_strb = s;
    bus.mem_write  = 1'b1;
    bus.mem_read   = also_read;
    @(negedge clk);
    check("wr_mem_req_ack", 32'(bus.mem_req_ack), 32'h1);
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    @(negedge clk);
    check("wr_ack_drop", 32'(bus.mem_req_ack), 32'h0);
    check("wr_no_rdv", 32'(bus.read_data_valid), 32'h0);
  endtask

  task automatic do_read(input bit is_inst, input logic [31:0] a,
                         input logic [31:0] exp, input int hold);
    int          lat;
    bit          done;
    bit          stable;
    logic [31:0] got;
    logic [31:0] want;
    int          base;
    base = 2 + int'(is_inst ? INST_LAT : DATA_LAT);
    if (is_inst) inst_q.push_back(exp);
    else         data_q.push_back(exp);
    @(negedge clk);
    if (is_inst) begin
      bus.pc = a;
      bus.inst_req_valid = 1'b1;
    end else begin
      bus.address  = a;
      bus.mem_read = 1'b1;
    end
    @(negedge clk);
    lat = 1;
    check(is_inst ? "inst_req_ack" : "rd_mem_req_ack", 32'(f_ack(is_inst)), 32'h1);
    bus.inst_req_valid = 1'b0;
    bus.mem_read       = 1'b0;
    done = f_valid(is_inst);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      done = f_valid(is_inst);
    end
    check(is_inst ? "inst_resp_seen" : "rd_resp_seen", 32'(done), 32'h1);
    if (!done) begin
      if (is_inst) void'(inst_q.pop_front());
      else         void'(data_q.pop_front());
      return;
    end
    check_range(is_inst ? "inst_latency" : "rd_latency", lat, base, base + EXTRA_MAX);
    got = f_data(is_inst);
    if (is_inst) want = inst_q.pop_front();
    else         want = data_q.pop_front();
    check(is_inst ? "instruction" : "read_data", got, want);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!f_valid(is_inst) || f_data(is_inst) !== got) stable = 1'b0;
    end
    if (hold > 0) check(is_inst ? "inst_hold" : "rd_hold", 32'(stable), 32'h1);
    if (is_inst) bus.inst_ack = 1'b1;
    else         bus.read_data_ack = 1'b1;
    @(negedge clk);
    bus.inst_ack      = 1'b0;
    bus.read_data_ack = 1'b0;
    check(is_inst ? "inst_valid_drop" : "rdv_drop", 32'(f_valid(is_inst)), 32'h0);
    check(is_inst ? "inst_kept" : "rd_kept", f_data(is_inst), got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    // is_wr is_inst addr wdata strb hold exp
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h2408_0005, 4'hF, 0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0,         4'h0, 0, 32'h2408_0005});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h00BB_00DD});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFF_F004, 32'h1122_3344, 4'hF, 0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 32'h1122_3344});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFF_F007, 32'h0,         4'h0, 0, 32'h1122_3344});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0027, 32'h1234_5678, 4'hA, 0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0024, 32'h0,         4'h0, 5, 32'h12FE_560D});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0024, 32'h0,         4'h0, 5, 32'h12FE_560D});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF, 0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0FFC, 32'h0,         4'h0, 0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_2FFC, 32'h0,         4'h0, 0, 32'hDEAD_BEEF});

    bus.pc = '0;          bus.inst_req_valid = 1'b0; bus.inst_ack = 1'b0;
    bus.address = '0;     bus.mem_write = 1'b0;      bus.write_data = '0;
    bus.write_strb = '0;  bus.mem_read = 1'b0;       bus.read_data_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Table-driven traffic
    foreach (vecs[k]) begin
      if (vecs[k].is_wr) do_write(vecs[k].addr, vecs[k].wdata, vecs[k].strb, 1'b0);
      else do_read(vecs[k].is_inst, vecs[k].addr, vecs[k].exp, vecs[k].hold);
    end
    check("prot_err_clean", 32'(bus.prot_err), 32'h0);

    // Write and read together: write served, read dropped, sticky error
    do_write(32'h0000_0030, 32'h55AA_55AA, 4'hF, 1'b1);
    check("prot_err_set", 32'(bus.prot_err), 32'h1);
    repeat (3) @(negedge clk);
    check("conflict_no_rdv", 32'(bus.read_data_valid), 32'h0);
    do_read(1'b0, 32'h0000_0030, 32'h55AA_55AA, 0);
    check("prot_err_sticky", 32'(bus.prot_err), 32'h1);

`ifndef MEM_RAND_DELAY_EN
    // Write commits on the same edge the fetch captures: fetch sees old word
    do_write(32'h0000_0040, 32'h0101_0101, 4'hF, 1'b0);
    inst_q.push_back(32'h0101_0101);
    @(negedge clk);
    bus.pc = 32'h0000_0040;
    bus.inst_req_valid = 1'b1;
    @(negedge clk);
    check("coll_inst_ack", 32'(bus.inst_req_ack), 32'h1);
    bus.inst_req_valid = 1'b0;
    bus.address = 32'h0000_0040;
    bus.write_data = 32'h0202_0202;
    bus.write_strb = 4'hF;
    bus.mem_write = 1'b1;
    @(negedge clk);
    check("coll_wr_ack", 32'(bus.mem_req_ack), 32'h1);
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("coll_inst_valid", 32'(bus.inst_valid), 32'h1);
    check("coll_old_word", bus.instruction, inst_q.pop_front());
    bus.inst_ack = 1'b1;
    @(negedge clk);
    bus.inst_ack = 1'b0;
    check("coll_inst_drop", 32'(bus.inst_valid), 32'h0);
    do_read(1'b0, 32'h0000_0040, 32'h0202_0202, 0);
`endif

    // Reset during data WAIT abandons the read and clears everything
    @(negedge clk);
    bus.address = 32'h0000_0024;
    bus.mem_read = 1'b1;
    @(negedge clk);
    check("rstw_ack", 32'(bus.mem_req_ack), 32'h1);
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_in_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("after_rst");
    do_read(1'b0, 32'h0000_0024, 32'h12FE_560D, 0);

    // Reset while a write sits in ACK: the write must not commit
    @(negedge clk);
    bus.address = 32'h0000_0024;
    bus.write_data = 32'hFFFF_FFFF;
    bus.write_strb = 4'hF;
    bus.mem_write = 1'b1;
    @(negedge clk);
    check("rsta_ack", 32'(bus.mem_req_ack), 32'h1);
    bus.mem_write = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_read(1'b0, 32'h0000_0024, 32'h12FE_560D, 0);
    do_read(1'b1, 32'h0000_0024, 32'h12FE_560D, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (memory depth 2^ADDR_W words).
REQ-002 SHALL have parameter INST_LAT, default 1, instruction-response wait cycles (0-15).
REQ-003 SHALL have parameter DATA_LAT, default 1, read-response wait cycles (0-15).
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports pc, input, 32, fetch address; inst_req_valid, input, 1; inst_req_ack, output, 1.
REQ-007 SHALL have ports instruction, output, 32; inst_valid, output, 1; inst_ack, input, 1.
REQ-008 SHALL have ports address, input, 32; mem_write, input, 1; write_data, input, 32; write_strb, input, 4; mem_read, input, 1; mem_req_ack, output, 1.
REQ-009 SHALL have ports read_data, output, 32; read_data_valid, output, 1; read_data_ack, input, 1.
REQ-010 SHALL have port prot_err, output, 1: sticky protocol-error flag.

Function
REQ-011 SHALL run two independent FSMs, instruction and data, each with states IDLE, ACK, WAIT, RESP.
REQ-012 Instruction IDLE: on inst_req_valid=1, latch pc[ADDR_W+1:2] and go to ACK; pc[1:0] and bits above ADDR_W+1 ignored (address wraps).
REQ-013 Instruction ACK: inst_req_ack=1 for exactly one cycle; next state WAIT if INST_LAT>0, else RESP; counter loaded with INST_LAT.
REQ-014 WAIT: decrement each cycle; enter RESP after the count reaches zero, so a request sampled at edge 0 gives inst_valid high from cycle 2+INST_LAT.
REQ-015 On entry to RESP, register the addressed word into instruction; hold instruction and inst_valid=1 until inst_ack=1 is sampled, then return to IDLE with inst_valid=0.
REQ-016 inst_ack SHALL be ignored in every state except RESP.
REQ-017 Data IDLE: on mem_write=1, latch address word index, write_data and write_strb, go to ACK; the write commits at the ACK-exit edge, one byte lane per strb bit; then return to IDLE; no read_data_valid.
REQ-018 Data IDLE: on mem_read=1, latch address, go to ACK (mem_req_ack=1 for one cycle), then WAIT/RESP per REQ-014 with DATA_LAT; read_data and read_data_valid are held until read_data_ack=1 is sampled.
REQ-019 mem_write and mem_read both high in IDLE: the write SHALL be served, the read dropped, and prot_err set.
REQ-020 A write committing on the same edge as an instruction or read capture to the same word: the capture SHALL return the old data.
REQ-021 Request inputs SHALL be ignored outside IDLE; a new request is accepted at the earliest in the cycle after the return to IDLE.
REQ-022 instruction and read_data SHALL hold their last value when not valid.

Reset
REQ-023 rst=0 SHALL force both FSMs to IDLE and clear inst_req_ack, inst_valid, mem_req_ack, read_data_valid, prot_err, instruction, read_data and the counters.
REQ-024 Reset mid-transaction SHALL abandon the transaction; a write still in ACK SHALL not commit; memory contents are not altered by reset.

Configuration
REQ-025 Macro MEM_RAND_DELAY_EN defined: an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle) adds lfsr[1:0] extra cycles to each WAIT count load.
REQ-026 MEM_RAND_DELAY_EN undefined: no LFSR is built and latencies are exactly INST_LAT and DATA_LAT.

Structure
REQ-027 Package cpu_mem_pkg SHALL hold the FSM state encoding, the counter width constant (4), and the LFSR seed and tap constants.
REQ-028 Storage SHALL be sub-module mem_resp_dpram: two synchronous read ports and one byte-strobed write port.

Verification
REQ-029 INST_LAT=1; preload word 4 = 32'h2408_0005; pc=32'h10 with inst_req_valid -> inst_req_ack at cycle 1, inst_valid with 32'h24080005 at cycle 3, held until inst_ack.
REQ-030 Write address 32'h20, data 32'hAABBCCDD, strb 4'b0101; then read 32'h20 with preload 0 -> mem_req_ack each; read_data 32'h00BB00DD.
REQ-031 inst_ack kept low 5 cycles in RESP -> inst_valid and instruction stable all 5 cycles; deassert one cycle after inst_ack is sampled.
REQ-032 mem_write and mem_read both high in IDLE -> write commits, no read_data_valid, prot_err=1 until reset.
REQ-033 rst low during data WAIT, then released -> all outputs 0, FSM in IDLE, next read served normally.
REQ-034 Address 32'hFFFF_F004 with ADDR_W=10 -> word index 1 (wrap); with MEM_RAND_DELAY_EN, latency stays in [2+LAT, 5+LAT].
